router_out_arbiter: RTL and testbench
=====================================

Name: router_out_arbiter

Overview:
Round-robin arbiter for one router output port, shared by NUM_PORTS input ports. Each input port's address decoder raises an active-low request toward this output. The arbiter grants one input at a time and holds the connection for one whole packet, released on the end of that input's frame. Losing requesters are flagged busy. The router instantiates one arbiter per output port; sel drives that output's data mux.

Parameters:
NUM_PORTS, 16, number of contending input ports (2..16, need not be a power of two)
IDX_W, 4, width of sel; must satisfy 2**IDX_W >= NUM_PORTS
WD_LIMIT, 1024, watchdog cycle limit for one connection (used only with the optional feature)

Ports:
clock  input  1  single clock; all logic on its posedge
reset_n  input  1  asynchronous active-low reset
req_n  input  NUM_PORTS  per-input request for this output, active low
frame_n  input  NUM_PORTS  per-input frame strobe, active low
grant_n  output  NUM_PORTS  one-hot-low grant, registered
busy_n  output  NUM_PORTS  active low; marks requesters denied while another input holds the port; registered
sel  output  IDX_W  index of the granted input; valid while conn_active=1
conn_active  output  1  high while a connection is held
timeout  output  1  one-cycle pulse on watchdog abort; tied 0 when the feature is compiled out

Behaviour:
- Clock and reset: one clock, posedge. Reset is asynchronous and active-low.
- Reset values: grant_n all 1, busy_n all 1, sel=0, conn_active=0, timeout=0.
- Reset internal state: state=IDLE, rr_ptr=0, seen_frame=0, wd_cnt=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req_n[i]=0, pick winner w = first requesting index searching upward from rr_ptr, wrapping NUM_PORTS-1 to 0.
  - Next edge: state=GRANT, grant_n[w]=0, sel=w, conn_active=1, seen_frame=0.
  - Latency: one cycle from sampled request to visible grant.
  - With no requests, stay in IDLE.
- GRANT:
  - seen_frame sets the first cycle frame_n[w]=0 is sampled.
  - Release condition (a): seen_frame=1 and frame_n[w]=1 is sampled (end of packet).
  - Release condition (b): seen_frame=0 and req_n[w]=1 is sampled (request abandoned before the packet started).
  - On either condition, go to RELEASE at the next edge.
- busy_n during GRANT:
  - Registered each cycle: busy_n[i]=0 iff i!=w and req_n[i]=0; otherwise 1.
  - busy_n[w] is always 1.
- RELEASE (exactly one cycle):
  - grant_n all 1, busy_n all 1, conn_active=0; sel holds its last value.
  - rr_ptr = (w+1) wrapped at NUM_PORTS (15 wraps to 0 when NUM_PORTS=16).
  - Next state is IDLE.
- Turnaround: the minimum gap between consecutive grants is 2 cycles (RELEASE, then IDLE).
- Requests arriving during RELEASE are evaluated in IDLE.
- req_n or frame_n activity on non-winners during GRANT never changes the winner.
- Async reset in any state immediately forces the reset values; the in-flight connection is dropped and rr_ptr returns to 0.
- Indices >= NUM_PORTS do not exist; the search wraps at NUM_PORTS-1.

Optional Feature:
Macro ROUTER_ARB_WATCHDOG_EN.
- Defined:
  - wd_cnt clears on entry to GRANT and increments each GRANT cycle.
  - When wd_cnt reaches WD_LIMIT-1 with no release, the next state is RELEASE and timeout=1 for that RELEASE cycle.
  - rr_ptr advances as for a normal release.
  - wd_cnt saturates and does not wrap.
- Not defined: no counter is synthesised, timeout is constant 0, and a connection can be held indefinitely.

Test Plan:
1. Reset and single request:
   - Stimulus: reset; then req_n[3]=0 at cycle 0; frame_n[3]=0 for cycles 2-9, frame_n[3]=1 at cycle 10.
   - Response: cycle 1 grant_n=16'hFFF7, sel=3, conn_active=1; cycle 11 RELEASE with grant_n=16'hFFFF; IDLE at cycle 12.
2. Three-way contention:
   - Stimulus: req_n[2], req_n[5], req_n[9] low together from reset, each sending one frame.
   - Response: grants in order 2, 5, 9; busy_n=16'hFDDF during port 2's connection; busy_n=16'hFDFF during port 5's connection.
3. Wrap-around:
   - Stimulus: port 15 served, then req_n[0] and req_n[14] low.
   - Response: port 0 granted first, port 14 second.
4. Abandoned request:
   - Stimulus: req_n[4]=0 for 3 cycles with no frame, then 1.
   - Response: RELEASE one cycle after req_n[4] is sampled high; the next grant favours port 5 over port 3 when both request.
5. Watchdog (macro defined, WD_LIMIT=8):
   - Stimulus: frame_n[6] held low.
   - Response: timeout=1 for exactly one cycle, 8 cycles after GRANT entry; grant_n returns to all 1.
   - Macro undefined: the grant holds and timeout stays 0.
6. Async reset mid-GRANT:
   - Stimulus: reset_n=0 asserted between clock edges.
   - Response: grant_n, busy_n all 1 and conn_active=0 without waiting for a clock edge; the next arbitration starts from port 0.

Source files
------------

// File: rtl/router_out_arbiter.sv
// Round-robin arbiter for one router output port: grants one input for a whole packet, flags losers busy.
// Optional watchdog abort of over-long connections is compiled in with ROUTER_ARB_WATCHDOG_EN.
module router_out_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int IDX_W     = 4,
  parameter int WD_LIMIT  = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req_n,
  input  logic [NUM_PORTS-1:0] frame_n,
  output logic [NUM_PORTS-1:0] grant_n,
  output logic [NUM_PORTS-1:0] busy_n,
  output logic [IDX_W-1:0]     sel,
  output logic                 conn_active,
  output logic                 timeout,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       rr_ptr_nxt;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       sel_nxt;
  logic                   found;
  logic                   seen_frame;
  logic                   seen_frame_nxt;
  logic                   release_req;
  logic                   wd_expire;
  logic [NUM_PORTS-1:0]   grant_nxt;
  logic [NUM_PORTS-1:0]   busy_nxt;
  logic                   conn_nxt;
  logic                   timeout_nxt;

  assign state_dbg = state;

  // Two passes: first the indices at or above rr_ptr, then the wrapped part below it.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && (i >= int'(rr_ptr)) && !req_n[i]) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && (i < int'(rr_ptr)) && !req_n[i]) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
  end

  // Before the packet starts the owner may walk away; after it starts only frame end releases.
  assign release_req = seen_frame ? frame_n[sel] : req_n[sel];

`ifdef ROUTER_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state != GRANT) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(WD_LIMIT - 1)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == GRANT) && (wd_cnt == WD_W'(WD_LIMIT - 1));
`else
  logic wd_unused;
  // The limit has no role without the watchdog.
  assign wd_unused = (WD_LIMIT > 0);
  assign wd_expire = 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      seen_frame  <= 1'b0;
      grant_n     <= '1;
      busy_n      <= '1;
      sel         <= '0;
      conn_active <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      seen_frame  <= seen_frame_nxt;
      grant_n     <= grant_nxt;
      busy_n      <= busy_nxt;
      sel         <= sel_nxt;
      conn_active <= conn_nxt;
      timeout     <= timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    seen_frame_nxt = seen_frame;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = GRANT;
          seen_frame_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_req || wd_expire) begin
          state_nxt  = RELEASE;
          rr_ptr_nxt = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
        end else if (!frame_n[sel]) begin
          seen_frame_nxt = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: values the output registers take at the next edge.
  always_comb begin
    owner       = (state == IDLE) ? winner : sel;
    grant_nxt   = '1;
    busy_nxt    = '1;
    sel_nxt     = sel;
    conn_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state_nxt)
      GRANT: begin
        sel_nxt  = owner;
        conn_nxt = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (IDX_W'(i) == owner) begin
            grant_nxt[i] = 1'b0;
          end else if (!req_n[i]) begin
            busy_nxt[i] = 1'b0;
          end
        end
      end
      RELEASE: timeout_nxt = (state == GRANT) && wd_expire && !release_req;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: hand-computed vectors, immediate assertions at each check.
// Compile with ROUTER_ARB_WATCHDOG_EN defined to exercise the watchdog path (WD_LIMIT=8).
module tb_router_out_arbiter;

  localparam int NP = 16;
  localparam int IW = 4;

  logic          clock;
  logic          reset_n;
  logic [NP-1:0] req_n;
  logic [NP-1:0] frame_n;
  logic [NP-1:0] grant_n;
  logic [NP-1:0] busy_n;
  logic [IW-1:0] sel;
  logic          conn_active;
  logic          timeout;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  router_out_arbiter #(.NUM_PORTS(NP), .IDX_W(IW), .WD_LIMIT(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_n       (req_n),
    .frame_n     (frame_n),
    .grant_n     (grant_n),
    .busy_n      (busy_n),
    .sel         (sel),
    .conn_active (conn_active),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Called in the first cycle the grant is visible: one-cycle frame, then request dropped.
  task automatic send_frame(input int p);
    frame_n[p] = 1'b0;
    cyc();
    frame_n[p] = 1'b1;
    req_n[p]   = 1'b1;
    cyc();
    chk($sformatf("rel_grant_p%0d", p), 32'(grant_n), 32'h0000_FFFF);
    chk($sformatf("rel_conn_p%0d", p), 32'(conn_active), 32'd0);
    chk($sformatf("rel_state_p%0d", p), 32'(state_dbg), 32'd2);
    chk($sformatf("rel_sel_p%0d", p), 32'(sel), 32'(p));
    cyc();
    chk($sformatf("idle_state_p%0d", p), 32'(state_dbg), 32'd0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req_n   = '1;
    frame_n = '1;
    #12;
    chk("rst_grant", 32'(grant_n), 32'h0000_FFFF);
    chk("rst_busy", 32'(busy_n), 32'h0000_FFFF);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_conn", 32'(conn_active), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    chk("idle_no_req", 32'(state_dbg), 32'd0);

    // Single request on port 3, frame low cycles 2-9.
    req_n[3] = 1'b0;
    cyc();
    chk("t1_grant", 32'(grant_n), 32'h0000_FFF7);
    chk("t1_sel", 32'(sel), 32'd3);
    chk("t1_conn", 32'(conn_active), 32'd1);
    chk("t1_busy", 32'(busy_n), 32'h0000_FFFF);
    cyc();
    frame_n[3] = 1'b0;
    repeat (8) cyc();
    chk("t1_hold_c10", 32'(grant_n), 32'h0000_FFF7);
    frame_n[3] = 1'b1;
    req_n[3]   = 1'b1;
    cyc();
    chk("t1_rel_grant", 32'(grant_n), 32'h0000_FFFF);
    chk("t1_rel_state", 32'(state_dbg), 32'd2);
    chk("t1_rel_sel", 32'(sel), 32'd3);
    cyc();
    chk("t1_idle", 32'(state_dbg), 32'd0);

    // Three-way contention from a fresh reset.
    pulse_reset();
    cyc();
    req_n = 16'hFDDB;
    cyc();
    chk("t2_grant2", 32'(grant_n), 32'h0000_FFFB);
    chk("t2_busy2", 32'(busy_n), 32'h0000_FDDF);
    send_frame(2);
    cyc();
    chk("t2_grant5", 32'(grant_n), 32'h0000_FFDF);
    chk("t2_sel5", 32'(sel), 32'd5);
    chk("t2_busy5", 32'(busy_n), 32'h0000_FDFF);
    send_frame(5);
    cyc();
    chk("t2_grant9", 32'(grant_n), 32'h0000_FDFF);
    chk("t2_busy9", 32'(busy_n), 32'h0000_FFFF);
    send_frame(9);

    // Wrap-around: after port 15, pointer returns to 0.
    req_n[15] = 1'b0;
    cyc();
    chk("t3_grant15", 32'(grant_n), 32'h0000_7FFF);
    send_frame(15);
    req_n[0]  = 1'b0;
    req_n[14] = 1'b0;
    cyc();
    chk("t3_grant0", 32'(grant_n), 32'h0000_FFFE);
    chk("t3_busy0", 32'(busy_n), 32'h0000_BFFF);
    send_frame(0);
    cyc();
    chk("t3_grant14", 32'(grant_n), 32'h0000_BFFF);
    chk("t3_sel14", 32'(sel), 32'd14);
    send_frame(14);

    // Abandoned request on port 4.
    req_n[4] = 1'b0;
    cyc();
    chk("t4_grant4", 32'(grant_n), 32'h0000_FFEF);
    cyc();
    cyc();
    req_n[4] = 1'b1;
    chk("t4_still4", 32'(grant_n), 32'h0000_FFEF);
    cyc();
    chk("t4_rel_state", 32'(state_dbg), 32'd2);
    chk("t4_rel_grant", 32'(grant_n), 32'h0000_FFFF);
    req_n[3] = 1'b0;
    req_n[5] = 1'b0;
    cyc();
    chk("t4_idle_gap", 32'(grant_n), 32'h0000_FFFF);
    chk("t4_idle_state", 32'(state_dbg), 32'd0);
    cyc();
    chk("t4_grant5", 32'(grant_n), 32'h0000_FFDF);
    chk("t4_busy5", 32'(busy_n), 32'h0000_FFF7);
    send_frame(5);
    cyc();
    chk("t4_grant3_wrap", 32'(grant_n), 32'h0000_FFF7);
    send_frame(3);

    // Long packet on port 6; non-winner activity must not disturb it.
    req_n[6] = 1'b0;
    cyc();
    chk("t5_grant6", 32'(grant_n), 32'h0000_FFBF);
    frame_n[6] = 1'b0;
    cyc();
    cyc();
    req_n[7]   = 1'b0;
    frame_n[7] = 1'b0;
    cyc();
    chk("t5_sel_kept", 32'(sel), 32'd6);
    chk("t5_busy7", 32'(busy_n), 32'h0000_FF7F);
    req_n[7]   = 1'b1;
    frame_n[7] = 1'b1;
    cyc();
    chk("t5_busy_clear", 32'(busy_n), 32'h0000_FFFF);
    repeat (3) cyc();
    chk("t5_g7_grant", 32'(grant_n), 32'h0000_FFBF);
    chk("t5_g7_timeout", 32'(timeout), 32'd0);
    cyc();
`ifdef ROUTER_ARB_WATCHDOG_EN
    chk("t5_wd_timeout", 32'(timeout), 32'd1);
    chk("t5_wd_grant", 32'(grant_n), 32'h0000_FFFF);
    chk("t5_wd_state", 32'(state_dbg), 32'd2);
    req_n[6]   = 1'b1;
    frame_n[6] = 1'b1;
    cyc();
    chk("t5_wd_pulse_end", 32'(timeout), 32'd0);
    chk("t5_wd_idle", 32'(state_dbg), 32'd0);
`else
    chk("t5_nowd_timeout", 32'(timeout), 32'd0);
    chk("t5_nowd_grant", 32'(grant_n), 32'h0000_FFBF);
    repeat (12) cyc();
    chk("t5_nowd_hold", 32'(grant_n), 32'h0000_FFBF);
    chk("t5_nowd_timeout2", 32'(timeout), 32'd0);
    frame_n[6] = 1'b1;
    req_n[6]   = 1'b1;
    cyc();
    chk("t5_nowd_rel", 32'(state_dbg), 32'd2);
    cyc();
    chk("t5_nowd_idle", 32'(state_dbg), 32'd0);
`endif

    // Async reset mid-GRANT, then arbitration restarts from port 0.
    req_n[1] = 1'b0;
    req_n[9] = 1'b0;
    cyc();
    chk("t6_grant9", 32'(grant_n), 32'h0000_FDFF);
    chk("t6_busy1", 32'(busy_n), 32'h0000_FFFD);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant_n), 32'h0000_FFFF);
    chk("t6_async_busy", 32'(busy_n), 32'h0000_FFFF);
    chk("t6_async_conn", 32'(conn_active), 32'd0);
    chk("t6_async_state", 32'(state_dbg), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    chk("t6_regrant1", 32'(grant_n), 32'h0000_FFFD);
    chk("t6_sel1", 32'(sel), 32'd1);
    chk("t6_busy9", 32'(busy_n), 32'h0000_FDFF);
    send_frame(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
